// File: rtl/key_pkg.sv
// Constants shared by the pushbutton debouncer and its per-channel slice.
package key_pkg;

  localparam int   KEY_DEBOUNCE_1MS_24M = 24000;
  // Raw DE1 KEY level when the button is not pushed.
  localparam logic KEY_RELEASED_N       = 1'b1;

endpackage

// File: rtl/key_debounce_if.sv
// Pushbutton bundle: raw active-low keys in, debounced level and strobes out.
interface key_debounce_if #(
  parameter int KN = 4
);

  logic [KN-1:0] key_n;
  logic [KN-1:0] key_state;
  logic [KN-1:0] key_press;
  logic [KN-1:0] key_release;

  modport master (
    output key_n,
    input  key_state,
    input  key_press,
    input  key_release
  );

  modport slave (
    input  key_n,
    output key_state,
    output key_press,
    output key_release
  );

endinterface

// File: rtl/key_debounce_ch.sv
// One pushbutton channel: two-flop synchronizer, stability counter and
// registered one-cycle press/release strobes.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE = KEY_DEBOUNCE_1MS_24M
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_state,
  output logic o_press,
  output logic o_release
);

  localparam int            CW       = $clog2(DEBOUNCE);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic          r_sync1_n;
  logic          r_sync2_n;
  logic          w_sample;
  logic [CW-1:0] r_cnt;
  logic          r_state;
  logic          r_press;
  logic          r_release;

  // Flops keep the raw polarity so reset parks them at the released level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1_n <= KEY_RELEASED_N;
      r_sync2_n <= KEY_RELEASED_N;
    end else begin
      r_sync1_n <= i_key_n;
      r_sync2_n <= r_sync1_n;
    end
  end

  assign w_sample = ~r_sync2_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_state   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      if (w_sample == r_state) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_LAST) begin
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_state   <= w_sample;
        r_cnt     <= '0;
        r_press   <= w_sample;
        r_release <= ~w_sample;
      end
    end
  end

  assign o_state   = r_state;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/key_debounce.sv
// Debounces KN active-low pushbuttons; one independent channel per key.
module key_debounce
  import key_pkg::*;
#(
  parameter int KN       = 4,
  parameter int DEBOUNCE = KEY_DEBOUNCE_1MS_24M
) (
  input  logic           clk,
  input  logic           rst_n,
  key_debounce_if.slave  bus
);

  logic [KN-1:0] w_state;
  logic [KN-1:0] w_press;
  logic [KN-1:0] w_release;

  for (genvar g = 0; g < KN; g++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE (DEBOUNCE)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_key_n   (bus.key_n[g]),
      .o_state   (w_state[g]),
      .o_press   (w_press[g]),
      .o_release (w_release[g])
    );
  end

  assign bus.key_state   = w_state;
  assign bus.key_press   = w_press;
  assign bus.key_release = w_release;

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce with DEBOUNCE=4, KN=4.
module tb_key_debounce;

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] pr;
    logic [3:0] rl;
  } exp_t;

  typedef struct {
    logic [3:0] keyN;
    int         hold;
    exp_t       exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t expQ[$];
  vec_t vecs[$];

  key_debounce_if #(.KN(4)) keyBus ();

  key_debounce #(
    .KN       (4),
    .DEBOUNCE (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (keyBus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name);
    exp_t e;
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s: scoreboard empty, no expectation queued", name);
    end else begin
      e = expQ.pop_front();
      if (keyBus.key_state !== e.st || keyBus.key_press !== e.pr ||
          keyBus.key_release !== e.rl) begin
        errors++;
        $display("[TB] FAIL %s: got state=%h press=%h release=%h, expected state=%h press=%h release=%h",
                 name, keyBus.key_state, keyBus.key_press, keyBus.key_release, e.st, e.pr, e.rl);
      end
    end
  endtask

  // Drive a key pattern, hold it for a number of edges, then compare just after the last edge.
  task automatic applyStimulus(input logic [3:0] keyN, input int hold, input exp_t e,
                               input string name);
    expQ.push_back(e);
    keyBus.key_n = keyN;
    repeat (hold) @(posedge clk);
    #1;
    checkOutput(name);
  endtask

  function automatic void addVec(input logic [3:0] keyN, input int hold,
                                 input logic [3:0] st, input logic [3:0] pr,
                                 input logic [3:0] rl);
    vec_t v;
    v.keyN = keyN;
    v.hold = hold;
    v.exp  = '{st: st, pr: pr, rl: rl};
    vecs.push_back(v);
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    keyBus.key_n = 4'hF;

    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      expQ.push_back('{st: 4'h0, pr: 4'h0, rl: 4'h0});
      checkOutput("reset_hold");
    end
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Clean press and release on channel 1.
    addVec(4'hD, 5, 4'h0, 4'h0, 4'h0);
    addVec(4'hD, 1, 4'h2, 4'h2, 4'h0);
    addVec(4'hD, 1, 4'h2, 4'h0, 4'h0);
    addVec(4'hF, 5, 4'h2, 4'h0, 4'h0);
    addVec(4'hF, 1, 4'h0, 4'h0, 4'h2);
    addVec(4'hF, 1, 4'h0, 4'h0, 4'h0);
    // Bounce on channel 2: low 3, high 1, five times, then held low.
    for (int r = 0; r < 5; r++) begin
      addVec(4'hB, 3, 4'h0, 4'h0, 4'h0);
      addVec(4'hF, 1, 4'h0, 4'h0, 4'h0);
    end
    addVec(4'hB, 5, 4'h0, 4'h0, 4'h0);
    addVec(4'hB, 1, 4'h4, 4'h4, 4'h0);
    addVec(4'hB, 1, 4'h4, 4'h0, 4'h0);
    addVec(4'hF, 5, 4'h4, 4'h0, 4'h0);
    addVec(4'hF, 1, 4'h0, 4'h0, 4'h4);
    addVec(4'hF, 1, 4'h0, 4'h0, 4'h0);
    // All channels together.
    addVec(4'h0, 5, 4'h0, 4'h0, 4'h0);
    addVec(4'h0, 1, 4'hF, 4'hF, 4'h0);
    addVec(4'h0, 1, 4'hF, 4'h0, 4'h0);
    addVec(4'hF, 5, 4'hF, 4'h0, 4'h0);
    addVec(4'hF, 1, 4'h0, 4'h0, 4'hF);
    addVec(4'hF, 1, 4'h0, 4'h0, 4'h0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].keyN, vecs[i].hold, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Asynchronous reset mid-cycle while all keys are pressed.
    applyStimulus(4'h0, 6, '{st: 4'hF, pr: 4'hF, rl: 4'h0}, "press_before_async");
    #2 rst_n = 1'b0;
    #1;
    expQ.push_back('{st: 4'h0, pr: 4'h0, rl: 4'h0});
    checkOutput("async_reset");
    keyBus.key_n = 4'hF;
    @(posedge clk);
    #3 rst_n = 1'b1;
    applyStimulus(4'hF, 3, '{st: 4'h0, pr: 4'h0, rl: 4'h0}, "after_async_idle");

    // Reset in the middle of a channel 3 count restarts the full latency.
    applyStimulus(4'h7, 4, '{st: 4'h0, pr: 4'h0, rl: 4'h0}, "midcount_pre");
    rst_n = 1'b0;
    #2;
    expQ.push_back('{st: 4'h0, pr: 4'h0, rl: 4'h0});
    checkOutput("midcount_reset");
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(4'h7, 1, '{st: 4'h0, pr: 4'h0, rl: 4'h0}, $sformatf("midcount_edge%0d", k));
    end
    applyStimulus(4'h7, 1, '{st: 4'h8, pr: 4'h8, rl: 4'h0}, "midcount_edge6");
    applyStimulus(4'h7, 1, '{st: 4'h8, pr: 4'h0, rl: 4'h0}, "midcount_edge7");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
